mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-port synchronous RAM (`memory`, CS/OE/WE interface with a shared tri-state data bus). It accepts independent read/write requests from two masters (port 0, e.g. instruction fetch; port 1, e.g. data access) and grants one at a time. For each granted request it generates the RAM chip-select, output-enable, write-enable and address sequence, drives or releases the data bus, and returns an ack pulse with read data.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a single-port CS/OE/WE RAM
// with a shared tri-state data bus. One transaction at a time; every output is registered.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_cs,
    output logic                  mem_oe,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  logic [DATA_WIDTH-1:0] mem_data,
    output logic [2:0]            state_dbg
);

    // Handshake: reqN is a level that stays high with weN/addrN/wdataN stable until
    // the one-cycle ackN; it is sampled only in IDLE, so a req that drops before then
    // is never seen, and a granted request always runs to completion (barring reset).
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RD_ACK  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last;
    logic                  port_q;
    logic                  port_nxt;
    logic                  take;
    logic                  gnt;
    logic                  drive_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        gnt       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take = 1'b1;
                    // on a tie the port that did not win last time goes first
                    gnt       = (req0 && req1) ? ~last : req1;
                    state_nxt = (gnt ? we1 : we0) ? WRITE : RD_ADDR;
                end
            end
            WRITE:   state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RD_ACK;
            RD_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        port_nxt = take ? gnt : port_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            port_q   <= 1'b0;
            mem_addr <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            drive_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            port_q <= port_nxt;
            if (take) begin
                last     <= gnt;
                mem_addr <= gnt ? addr1 : addr0;
                wdata_q  <= gnt ? wdata1 : wdata0;
            end
            if (state == RD_CAP) begin
                rdata <= mem_data;
            end
            // outputs are decoded from the next state so they line up with it
            busy    <= (state_nxt != IDLE);
            mem_cs  <= (state_nxt == WRITE) || (state_nxt == RD_ADDR) || (state_nxt == RD_CAP);
            mem_we  <= (state_nxt == WRITE);
            mem_oe  <= (state_nxt == RD_ADDR) || (state_nxt == RD_CAP);
            drive_q <= (state_nxt == WRITE);
            ack0    <= ((state_nxt == WRITE) || (state_nxt == RD_ACK)) && !port_nxt;
            ack1    <= ((state_nxt == WRITE) || (state_nxt == RD_ACK)) && port_nxt;
        end
    end

    assign mem_data  = drive_q ? wdata_q : 'z;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM on the shared bus, a transaction-level
// reference model with a read-data expected queue, directed cases and random traffic.
module tb_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, mem_cs, mem_oe, mem_we;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic [2:0]    state_dbg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .state_dbg(state_dbg)
    );

    // ---------------- RAM device on the bus ----------------
    logic [DW-1:0] tb_ram [256] = '{default: 8'h00};
    assign mem_data = (mem_cs && mem_oe) ? tb_ram[mem_addr] : 8'bz;
    always @(posedge clk) begin
        if (mem_cs && mem_we) tb_ram[mem_addr] <= mem_data;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction granted at edge g: a write strobes for the cycle after g and frees
    // the arbiter at g+2; a read strobes after g and g+1, acks after g+2 (data
    // captured at g+2) and frees at g+4.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [256];
    int            cyc = 0;
    int            g = 0;
    bit            act = 0;
    bit            m_last = 1;
    bit            m_port = 0;
    bit            m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            mon_on = 0;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                act = 0;
                m_last = 1;
                m_rdata = '0;
                exp_q.delete();
            end else begin
                if (act && !m_we && cyc == g + 2) begin
                    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
                end
                if (act && cyc >= g + (m_we ? 2 : 4)) act = 0;
                if (!act && (req0 || req1)) begin
                    m_port  = (req0 && req1) ? !m_last : req1;
                    m_we    = m_port ? we1 : we0;
                    m_addr  = m_port ? addr1 : addr0;
                    m_wdata = m_port ? wdata1 : wdata0;
                    m_last  = m_port;
                    act     = 1;
                    g       = cyc;
                    if (m_we) model_mem[m_addr] = m_wdata;
                    else      exp_q.push_back(model_mem[m_addr]);
                end
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int ack_log[$];

    initial begin
        int ph;
        bit s_w, s_r, a_r;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                ph  = cyc - g;
                s_w = act && m_we && ph == 0;
                s_r = act && !m_we && ph <= 1;
                a_r = act && !m_we && ph == 2;
                check("busy", busy, s_w || s_r || a_r);
                check("mem_cs", mem_cs, s_w || s_r);
                check("mem_we", mem_we, s_w);
                check("mem_oe", mem_oe, s_r);
                check("ack0", ack0, (s_w || a_r) && !m_port);
                check("ack1", ack1, (s_w || a_r) && m_port);
                check("rdata", rdata, m_rdata);
                check("oe_we_excl", mem_oe && mem_we, 0);
                check("ack_excl", ack0 && ack1, 0);
                if (mem_cs) check("mem_addr", mem_addr, m_addr);
                if (mem_we) check("mem_data_wr", mem_data, m_wdata);
                if (ack0) begin ack0_cnt++; ack_log.push_back(0); end
                if (ack1) begin ack1_cnt++; ack_log.push_back(1); end
            end
        end
    end

    // ---------------- driver ----------------
    // Entered just after a posedge; leaves req dropped just after the posedge that
    // follows the ack, so back-to-back calls keep req continuously high.
    task automatic xfer(input bit p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
        bit got;
        got = 0;
        lat = 0;
        rd  = '0;
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (p ? ack1 : ack0) begin
                got = 1;
                rd  = rdata;
            end
        end
        check(p ? "ack1_seen" : "ack0_seen", got, 1);
        @(posedge clk);
        #1;
        if (p) req1 = 0; else req0 = 0;
    endtask

    task automatic port_random(input bit p, input int n);
        int lat;
        logic [DW-1:0] rd;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            xfer(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 DW'($urandom_range(0, 255)), lat, rd);
        end
    endtask

    task automatic port_writes(input bit p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat;
        logic [DW-1:0] rd;
        for (int k = 0; k < 4; k++) xfer(p, 1'b1, a, d, lat, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int            lat;
        logic [DW-1:0] rd;
        logic [DW-1:0] fill [8];
        logic [DW-1:0] keep7;
        int            a0, a1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        @(posedge clk); #1;
        mon_on = 1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 0;
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rdata", rdata, 0);

        // single write then cross-port read of the same address
        xfer(0, 1'b1, 8'h03, 8'hDE, lat, rd);
        check("wr_latency", lat, 2);
        check("ram_03", tb_ram[8'h03], 8'hDE);
        xfer(1, 1'b0, 8'h03, 8'h00, lat, rd);
        check("rd_latency", lat, 4);
        check("rd_03", rd, 8'hDE);

        // both ports writing continuously: strict alternation starting with port 0
        ack_log.delete();
        fork
            port_writes(0, 8'h10, 8'hA0);
            port_writes(1, 8'h20, 8'hB0);
        join
        check("alt_count", ack_log.size(), 8);
        check("alt_first", ack_log[0], 0);
        for (int i = 1; i < ack_log.size(); i++) check("alt_order", ack_log[i], !ack_log[i-1]);
        check("ram_10", tb_ram[8'h10], 8'hA0);
        check("ram_20", tb_ram[8'h20], 8'hB0);

        // fill 0..7 through alternating ports, read back through the other port
        for (int i = 0; i < 8; i++) begin
            fill[i] = DW'($urandom_range(0, 255));
            xfer(1'(i % 2), 1'b1, AW'(i), fill[i], lat, rd);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1'((i + 1) % 2), 1'b0, AW'(i), 8'h00, lat, rd);
            check("fill_rd", rd, fill[i]);
        end

        // reset during RD_CAP drops the read with no ack
        xfer(0, 1'b1, 8'h04, 8'h45, lat, rd);
        a1 = ack1_cnt;
        req1 = 1; we1 = 0; addr1 = 8'h04; wdata1 = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        req1 = 0;
        @(posedge clk); #1;
        reset = 0;
        check("rstmid_ack1", ack1_cnt - a1, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_oe", mem_oe, 0);
        check("rstmid_addr", mem_addr, 0);
        check("rstmid_rdata", rdata, 0);
        xfer(1, 1'b0, 8'h04, 8'h00, lat, rd);
        check("rd_04_after_rst", rd, 8'h45);

        // a single-cycle req0 pulse while busy is never granted
        a0 = ack0_cnt;
        keep7 = tb_ram[7];
        fork
            xfer(1, 1'b0, 8'h02, 8'h00, lat, rd);
            begin
                @(posedge clk); #1;
                req0 = 1; we0 = 1; addr0 = 8'h07; wdata0 = ~keep7;
                @(posedge clk); #1;
                req0 = 0;
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        check("pulse_no_ack0", ack0_cnt - a0, 0);
        check("pulse_ram7", tb_ram[7], keep7);

        // random concurrent traffic from both ports
        fork
            port_random(0, 60);
            port_random(1, 60);
        join
        repeat (6) begin @(posedge clk); #1; end
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
